// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: sequences start, data (from the serializer), optional parity
// and stop bits onto the TX line, one bit per clock.
module uart_tx_frame_ctrl #(
   parameter int DATAWIDTH = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_dataValid,
   input  logic                 i_parEn,
   input  logic                 i_parType,
   input  logic [DATAWIDTH-1:0] i_dataIn,
   input  logic                 i_serDataIn,
   input  logic                 i_serDone,
   output logic                 o_serLoad,
   output logic                 o_serEn,
   output logic                 o_txOut,
   output logic                 o_busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_par_bit;
   logic   r_par_en;
   logic   r_stop_cnt;
   logic   w_accept;
   logic   w_last_stop;

   // With two stop bits the counter marks the second one; with one stop bit every STOP cycle is final.
   assign w_last_stop = (r_state == S_STOP) && ((STOP_BITS < 2) || r_stop_cnt);
   assign o_busy      = (r_state != S_IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_par_bit  <= 1'b0;
         r_par_en   <= 1'b0;
         r_stop_cnt <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_par_bit <= (^i_dataIn) ^ i_parType;
            r_par_en  <= i_parEn;
         end
         if ((r_state == S_STOP) && !w_last_stop)
            r_stop_cnt <= 1'b1;
         else
            r_stop_cnt <= 1'b0;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      o_txOut   = 1'b1;
      o_serEn   = 1'b0;
      o_serLoad = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_dataValid) begin
               w_accept = 1'b1;
               w_next   = S_START;
            end
         end
         S_START: begin
            o_txOut = 1'b0;
            o_serEn = 1'b1;
            w_next  = S_DATA;
         end
         S_DATA: begin
            // serDone is the sole end-of-data marker; its cycle carries the MSB
            o_txOut = i_serDataIn;
            o_serEn = !i_serDone;
            if (i_serDone)
               w_next = r_par_en ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            o_txOut = r_par_bit;
            w_next  = S_STOP;
         end
         S_STOP: begin
            if (w_last_stop) begin
               if (i_dataValid) begin
                  w_accept = 1'b1;
                  w_next   = S_START;
               end else begin
                  w_next = S_IDLE;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
      o_serLoad = w_accept;
   end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: one instance with a single stop bit, one with two, each driving
// a simple serializer model; a frame-level queue model checks every cycle.
module tb_uart_tx_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dv, pe, pt;
   logic [7:0] din [2];
   logic [1:0] sload, sen, tx, busy, sdat, sdone;
   logic [7:0] sbyte [2];
   logic [3:0] scnt [2];

   int n_tests = 0;
   int n_fail  = 0;
   int stop_bits [2] = '{1, 2};

   typedef struct {
      logic tx;
      logic sen;
   } exp_t;
   exp_t mq [2][$];

   typedef struct {
      int         inst;
      logic [7:0] d;
      logic       pe;
      logic       pt;
      string      bits;
   } vec_t;
   vec_t vt [6];

   always #5 clk = ~clk;

   uart_tx_frame_ctrl #(.DATAWIDTH(8), .STOP_BITS(1)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_dataValid(dv[0]), .i_parEn(pe[0]), .i_parType(pt[0]),
      .i_dataIn(din[0]), .i_serDataIn(sdat[0]), .i_serDone(sdone[0]), .o_serLoad(sload[0]),
      .o_serEn(sen[0]), .o_txOut(tx[0]), .o_busy(busy[0]));

   uart_tx_frame_ctrl #(.DATAWIDTH(8), .STOP_BITS(2)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_dataValid(dv[1]), .i_parEn(pe[1]), .i_parType(pt[1]),
      .i_dataIn(din[1]), .i_serDataIn(sdat[1]), .i_serDone(sdone[1]), .o_serLoad(sload[1]),
      .o_serEn(sen[1]), .o_txOut(tx[1]), .o_busy(busy[1]));

   // serializer model: scnt counts bits shifted out; bit scnt-1 is on the line, done at 8
   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            scnt[k]  <= 4'd0;
            sbyte[k] <= 8'd0;
         end else if (sload[k]) begin
            scnt[k]  <= 4'd0;
            sbyte[k] <= din[k];
         end else if (sen[k] && scnt[k] < 4'd8) begin
            scnt[k] <= scnt[k] + 4'd1;
         end
      end
   end

   always_comb begin
      sdat  = '0;
      sdone = '0;
      for (int k = 0; k < 2; k++) begin
         sdat[k]  = (scnt[k] == 4'd0) ? 1'b0 : sbyte[k][3'(scnt[k] - 4'd1)];
         sdone[k] = (scnt[k] == 4'd8);
      end
   end

   task automatic chk(input string nm, input int k, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] t=%0t got=%b want=%b", nm, k, $time, act, exp);
      end
   endtask

   task automatic push_frame(input int k, input logic [7:0] d, input logic p_en, input logic p_ty);
      exp_t e;
      e.tx = 1'b0; e.sen = 1'b1; mq[k].push_back(e);
      for (int i = 0; i < 8; i++) begin
         e.tx = d[i]; e.sen = (i != 7); mq[k].push_back(e);
      end
      if (p_en) begin
         e.tx = (^d) ^ p_ty; e.sen = 1'b0; mq[k].push_back(e);
      end
      for (int s = 0; s < stop_bits[k]; s++) begin
         e.tx = 1'b1; e.sen = 1'b0; mq[k].push_back(e);
      end
   endtask

   task automatic monitor();
      exp_t e;
      logic eb, acc;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
               mq[k].delete();
               chk("rst.tx", k, tx[k], 1'b1);
               chk("rst.busy", k, busy[k], 1'b0);
               chk("rst.serLoad", k, sload[k], 1'b0);
               chk("rst.serEn", k, sen[k], 1'b0);
            end else begin
               if (mq[k].size() == 0) begin
                  e.tx = 1'b1; e.sen = 1'b0; eb = 1'b0;
               end else begin
                  e = mq[k][0]; eb = 1'b1;
               end
               acc = dv[k] && (mq[k].size() <= 1);
               chk("mdl.tx", k, tx[k], e.tx);
               chk("mdl.busy", k, busy[k], eb);
               chk("mdl.serEn", k, sen[k], e.sen);
               chk("mdl.serLoad", k, sload[k], acc);
               if (mq[k].size() > 0) void'(mq[k].pop_front());
               if (acc) push_frame(k, din[k], pe[k], pt[k]);
            end
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      @(posedge clk); #1;
      dv[v.inst] = 1'b1; din[v.inst] = v.d; pe[v.inst] = v.pe; pt[v.inst] = v.pt;
      @(posedge clk); #1;
      dv[v.inst] = 1'b0;
      for (int i = 0; i < v.bits.len(); i++) begin
         @(negedge clk);
         chk("vec.tx", i, tx[v.inst], v.bits.getc(i) == 8'h31);
         chk("vec.busy", i, busy[v.inst], 1'b1);
      end
      @(negedge clk);
      chk("vec.idle", v.inst, busy[v.inst], 1'b0);
   endtask

   initial begin
      dv = '0; pe = '0; pt = '0;
      din[0] = 8'h00; din[1] = 8'h00;
      vt[0] = '{0, 8'hA5, 1'b0, 1'b0, "0101001011"};
      vt[1] = '{0, 8'hA5, 1'b1, 1'b0, "01010010101"};
      vt[2] = '{0, 8'hA5, 1'b1, 1'b1, "01010010111"};
      vt[3] = '{1, 8'hFF, 1'b0, 1'b0, "01111111111"};
      vt[4] = '{0, 8'h3C, 1'b0, 1'b0, "0001111001"};
      vt[5] = '{1, 8'h01, 1'b1, 1'b0, "010000000111"};
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk("idle.tx", k, tx[k], 1'b1);
            chk("idle.busy", k, busy[k], 1'b0);
            chk("idle.serLoad", k, sload[k], 1'b0);
            chk("idle.serEn", k, sen[k], 1'b0);
         end
      end

      for (int i = 0; i < 6; i++) run_vec(vt[i]);

      // back-to-back frames: dataValid held for 30 cycles
      @(posedge clk); #1;
      dv[0] = 1'b1; din[0] = 8'h01; pe[0] = 1'b1; pt[0] = 1'b0;
      for (int j = 0; j < 33; j++) begin
         @(posedge clk); #1;
         if (j == 29) dv[0] = 1'b0;
         @(negedge clk);
         chk("b2b.tx", j, tx[0], vt[5].bits.getc(j % 11) == 8'h31);
         chk("b2b.serLoad", j, sload[0], (j % 11 == 10) && (j < 29));
      end
      @(negedge clk);
      chk("b2b.idle", 0, busy[0], 1'b0);

      // reset in the 4th data cycle aborts the frame at once
      @(posedge clk); #1;
      dv[0] = 1'b1; din[0] = 8'hA5; pe[0] = 1'b0;
      @(posedge clk); #1;
      dv[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst.busy", 0, busy[0], 1'b1);
      chk("pre_rst.serEn", 0, sen[0], 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst.tx", 0, tx[0], 1'b1);
      chk("async_rst.busy", 0, busy[0], 1'b0);
      chk("async_rst.serEn", 0, sen[0], 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_vec(vt[4]);

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            dv[k]  = ($urandom_range(0, 2) == 0);
            din[k] = 8'($urandom);
            pe[k]  = 1'($urandom);
            pt[k]  = 1'($urandom);
         end
      end
      @(posedge clk); #1;
      dv = '0;
      repeat (30) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
UART transmit frame controller that drives the TX serializer and forms the line output. It accepts a byte from the upstream producer and loads the serializer. It then sequences start bit, data bits (taken from the serializer's serial output), optional parity bit and stop bit(s) onto the TX line. One clock cycle equals one bit period: clk is the baud-rate clock.

Parameters:
DATAWIDTH, 8, data bits per frame; must match the serializer's DATAWIDTH.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  input  1  bit-rate clock, rising edge.
rst  input  1  asynchronous, active-low reset.
dataValid  input  1  upstream request; a byte is present on the shared data bus (the serializer's dataIn is wired to the same bus).
parEn  input  1  parity enable; sampled at frame acceptance.
parType  input  1  0 = even parity, 1 = odd parity; sampled at acceptance.
dataIn  input  DATAWIDTH  byte, sampled at acceptance for the parity calculation.
serDataIn  input  1  serializer serial output (dataOut).
serDone  input  1  serializer done flag (SerializerDn).
serLoad  output  1  to serializer dataValid; loads the byte.
serEn  output  1  to serializer serializerEn; shifts one bit.
txOut  output  1  UART line; idle high.
busy  output  1  high while a frame is in progress.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP.
- Reset (asynchronous, any state): state=IDLE, parity/config registers=0, stop counter=0. Outputs settle immediately to txOut=1, busy=0, serLoad=0, serEn=0. Reset mid-frame aborts the frame with no partial stop bit.
- Acceptance: in IDLE, or in the final STOP cycle, dataValid=1 causes:
  - serLoad=1 combinationally in the same cycle;
  - parBit <= ^dataIn ^ parType, and parEn is latched;
  - next state = START.
- dataValid is ignored in all other cycles; the producer must hold or drop it. No buffering is provided.
- START: txOut=0, serEn=1, so bit0 appears on serDataIn in the next cycle.
- DATA: txOut=serDataIn, serEn=!serDone.
  - The state lasts exactly DATA cycles, LSB first.
  - The cycle where serDone=1 carries the MSB.
  - At the end of that cycle: next state = PARITY if parEn is latched, else STOP.
- PARITY: txOut=parBit, held for 1 cycle, then STOP.
- STOP: txOut=1, held for STOP_BITS cycles using a 1-bit counter.
  - Final stop cycle with dataValid=1: next state = START (back-to-back frames, no idle gap).
  - Otherwise: next state = IDLE.
- busy=1 in START, DATA, PARITY and STOP; busy=0 only in IDLE.
- txOut, serLoad and serEn are combinational decodes of the registered state (plus serDataIn/serDone/dataValid). All internal state is registered on posedge clk.
- Frame length = 1 + DATAWIDTH + parEn + STOP_BITS cycles.
  - Example, default parameters: 10 cycles without parity, 11 with parity.
- serDone is trusted as the only end-of-data indication; the block has no internal bit counter for data.
- serDone still high from a previous frame is harmless: the serializer clears its pointer on serLoad before START completes.

Test Plan:
- Reset then idle for 5 cycles -> txOut=1, busy=0, serLoad=0, serEn=0 on every cycle.
- dataIn=0xA5, parEn=0, one-cycle dataValid -> txOut sequence 0,1,0,1,0,0,1,0,1,1 (10 cycles); busy high for 10 cycles; serLoad pulses once; serEn high for 8 cycles.
- dataIn=0xA5, parEn=1, parType=0 -> parity bit 0 after the data bits, 11-cycle frame. Repeat with parType=1 -> parity bit 1.
- dataIn=0x01, parEn=1, parType=0, dataValid held high for 30 cycles -> back-to-back frames with a single 1 between them (the stop bit), no idle gap. Parity bit=1 in each frame. Second serLoad coincides with the stop cycle.
- STOP_BITS=2, dataIn=0xFF, parEn=0 -> frame 0, then eight 1s, then two 1s; busy low at cycle 11.
- Assert rst in the 4th DATA cycle of a frame -> txOut=1 and busy=0 immediately. After release, a new dataValid with 0x3C produces a correct full frame 0,0,0,1,1,1,1,0,0,1.
